// File: rtl/adaptive_signal_ctrl.sv
// adaptive_signal_ctrl
// Adaptive N-approach intersection controller. It serves one approach at a
// time in round-robin order, cycling GREEN -> YELLOW -> ALL_RED. Each green
// time is picked from the served approach's queue sensors when the approach
// is selected. Approaches with no demand can optionally be skipped.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-low reset
//   enable         1 = run, 0 = freeze timer/phase/lamps/index
//   near_sensor    per-approach sensor at queue position 1
//   far_sensor     per-approach sensor at queue position 5
//   lights         per-approach lamp code at [2i+1:2i]: 00 red, 01 green, 10 yellow
//   active_idx     approach currently (or most recently) served
//   phase          00 ALL_RED, 01 GREEN, 10 YELLOW
//   timer          remaining cycles in the current phase minus 1
//   rotation_done  one-cycle pulse when service moves to an index <= previous
module adaptive_signal_ctrl #(
    parameter int N_WAY      = 4,
    parameter int CNT_W      = 8,
    parameter int T_LONG     = 60,
    parameter int T_MID      = 40,
    parameter int T_SHORT    = 20,
    parameter int T_YELLOW   = 4,
    parameter int T_CLEAR    = 2,
    parameter int SKIP_EMPTY = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [N_WAY-1:0]           near_sensor,
    input  logic [N_WAY-1:0]           far_sensor,
    output logic [2*N_WAY-1:0]         lights,
    output logic [$clog2(N_WAY)-1:0]   active_idx,
    output logic [1:0]                 phase,
    output logic [CNT_W-1:0]           timer,
    output logic                       rotation_done
);

    localparam int IDX_W = $clog2(N_WAY);

    typedef enum logic [1:0] {
        ALL_RED = 2'b00,
        GREEN   = 2'b01,
        YELLOW  = 2'b10
    } phase_t;

    localparam logic [CNT_W-1:0] LONG_M1   = CNT_W'(T_LONG - 1);
    localparam logic [CNT_W-1:0] MID_M1    = CNT_W'(T_MID - 1);
    localparam logic [CNT_W-1:0] SHORT_M1  = CNT_W'(T_SHORT - 1);
    localparam logic [CNT_W-1:0] YELLOW_M1 = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] CLEAR_M1  = CNT_W'(T_CLEAR - 1);

    // Every duration must be at least one cycle and its "minus one" load
    // value must fit the timer.
    if (N_WAY < 2 || N_WAY > 8 ||
        T_LONG   < 1 || T_LONG   > (1 << CNT_W) ||
        T_MID    < 1 || T_MID    > (1 << CNT_W) ||
        T_SHORT  < 1 || T_SHORT  > (1 << CNT_W) ||
        T_YELLOW < 1 || T_YELLOW > (1 << CNT_W) ||
        T_CLEAR  < 1 || T_CLEAR  > (1 << CNT_W)) begin : g_cfg_error
        $error("adaptive_signal_ctrl: invalid N_WAY or phase duration for CNT_W");
    end

    logic [N_WAY-1:0]   near_q;
    logic [N_WAY-1:0]   far_q;
    logic [N_WAY-1:0]   demand;
    phase_t             phase_reg;
    logic [CNT_W-1:0]   timer_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [2*N_WAY-1:0] lights_reg;
    logic               rot_reg;

    logic [IDX_W-1:0]   cand [N_WAY];
    logic [IDX_W-1:0]   next_idx;
    logic [CNT_W-1:0]   green_m1;

    assign demand = near_q | far_q;

    // cand[gi] is the approach gi+1 positions after the current one; the last
    // candidate wraps back onto the current approach itself.
    for (genvar gi = 0; gi < N_WAY; gi++) begin : g_cand
        assign cand[gi] = IDX_W'((int'(idx_reg) + gi + 1) % N_WAY);
    end

    // Scan from the farthest candidate to the nearest so that the nearest
    // demanding approach wins. With no demand, the plain successor is used.
    always_comb begin
        next_idx = cand[0];
        if (SKIP_EMPTY != 0) begin
            for (int k = N_WAY - 1; k >= 0; k--) begin
                if (demand[cand[k]]) begin
                    next_idx = cand[k];
                end
            end
        end
    end

    always_comb begin
        green_m1 = SHORT_M1;
        if (near_q[next_idx] && far_q[next_idx]) begin
            green_m1 = LONG_M1;
        end else if (near_q[next_idx]) begin
            green_m1 = MID_M1;
        end
    end

    function automatic logic [2*N_WAY-1:0] lamp(input logic [IDX_W-1:0] idx,
                                                 input logic [1:0]       code);
        logic [2*N_WAY-1:0] w;
        w = '0;
        for (int i = 0; i < N_WAY; i++) begin
            if (idx == IDX_W'(i)) begin
                w[2*i +: 2] = code;
            end
        end
        return w;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            near_q     <= '0;
            far_q      <= '0;
            phase_reg  <= ALL_RED;
            timer_reg  <= CLEAR_M1;
            idx_reg    <= IDX_W'(N_WAY - 1);
            lights_reg <= '0;
            rot_reg    <= 1'b0;
        end else begin
            near_q  <= near_sensor;
            far_q   <= far_sensor;
            rot_reg <= 1'b0;
            if (enable) begin
                if (timer_reg != '0) begin
                    timer_reg <= timer_reg - CNT_W'(1);
                end else begin
                    case (phase_reg)
                        ALL_RED: begin
                            phase_reg  <= GREEN;
                            timer_reg  <= green_m1;
                            idx_reg    <= next_idx;
                            lights_reg <= lamp(next_idx, 2'b01);
                            rot_reg    <= (next_idx <= idx_reg);
                        end
                        GREEN: begin
                            phase_reg  <= YELLOW;
                            timer_reg  <= YELLOW_M1;
                            lights_reg <= lamp(idx_reg, 2'b10);
                        end
                        default: begin
                            phase_reg  <= ALL_RED;
                            timer_reg  <= CLEAR_M1;
                            lights_reg <= '0;
                        end
                    endcase
                end
            end
        end
    end

    assign lights        = lights_reg;
    assign active_idx    = idx_reg;
    assign phase         = phase_reg;
    assign timer         = timer_reg;
    assign rotation_done = rot_reg;

endmodule
